serial_word_checker: RTL and testbench

Parametrised serial code-word checker. It accumulates a serial bit stream into WIDTH-bit words and compares each word against a fixed PATTERN. It runs in two modes: framed (non-overlapping words, error flagged on mismatch) and sliding (overlapping search, match flagged on every hit). It sits in the same serial front end as the existing 3-bit error detector and replaces it with a generalised checker that adds input qualification and a saturating error counter.

---
 rtl/serial_word_checker.sv | 75 +++++++
 tb/tb_serial_word_checker.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/serial_word_checker.sv
// serial_word_checker: serial code-word checker, framed (error on mismatch) or sliding (match on every hit),
// with input qualification and a saturating error counter.
module serial_word_checker #(
    parameter int               WIDTH   = 3,
    parameter logic [WIDTH-1:0] PATTERN = 3'b110,
    parameter int               CNT_W   = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             din_i,
    input  logic             din_valid_i,
    input  logic             mode_i,
    input  logic             clear_cnt_i,
    output logic             match_o,
    output logic             err_o,
    output logic             frame_done_o,
    output logic [CNT_W-1:0] err_count_o
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic {FILL, FULL} fill_e;

    logic [WIDTH-1:0] sr_q, sr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    fill_e            state_q, state_d;
    logic             mode_q;
    logic             match_q, match_d;
    logic             err_q, err_d;
    logic             fd_q, fd_d;
    logic [CNT_W-1:0] ecnt_q, ecnt_d;
    logic             restart, acc, last, eval, hit;

    always_comb begin
        restart = mode_i != mode_q;
        acc     = din_valid_i && !restart;
        last    = cnt_q == CW'(WIDTH - 1);
        sr_d    = acc ? {sr_q[WIDTH-2:0], din_i} : sr_q;
        hit     = sr_d == PATTERN;
        cnt_d   = !acc ? cnt_q : last ? '0 : cnt_q + 1'b1;
        state_d = (acc && mode_q && last) ? FULL : state_q;
        // Sliding mode keeps evaluating every accepted bit once the window has filled.
        eval    = acc && (last || (mode_q && state_q == FULL));
        match_d = eval && hit;
        err_d   = eval && !mode_q && !hit;
        fd_d    = eval && !mode_q;
        ecnt_d  = clear_cnt_i ? '0 : (err_d && ecnt_q != '1) ? ecnt_q + 1'b1 : ecnt_q;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sr_q    <= '0;
            cnt_q   <= '0;
            state_q <= FILL;
            mode_q  <= mode_i;
            match_q <= 1'b0;
            err_q   <= 1'b0;
            fd_q    <= 1'b0;
            ecnt_q  <= '0;
        end else begin
            sr_q    <= restart ? '0 : sr_d;
            cnt_q   <= restart ? '0 : cnt_d;
            state_q <= restart ? FILL : state_d;
            mode_q  <= mode_i;
            match_q <= match_d;
            err_q   <= err_d;
            fd_q    <= fd_d;
            ecnt_q  <= ecnt_d;
        end
    end

    assign match_o      = match_q;
    assign err_o        = err_q;
    assign frame_done_o = fd_q;
    assign err_count_o  = ecnt_q;
endmodule

// File: tb/tb_serial_word_checker.sv
// tb_serial_word_checker: directed scenario tasks for serial_word_checker (WIDTH=3, PATTERN=110),
// with a second instance using a 2-bit counter for saturation.
module tb_serial_word_checker;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       din = 1'b0;
    logic       din_valid = 1'b0;
    logic       mode = 1'b0;
    logic       clr = 1'b0;
    logic       m, e, f, ms, es, fs;
    logic [7:0] cnt;
    logic [1:0] cnt_s;
    logic [7:0] ec = '0;
    logic [1:0] ecs = '0;
    int         checks = 0;
    int         failures = 0;
    wire [15:0] obs = {m, e, f, ms, es, fs, cnt, cnt_s};

    always #5 clk = ~clk;

    serial_word_checker dut (
        .clk_i(clk), .rst_i(rst), .din_i(din), .din_valid_i(din_valid), .mode_i(mode),
        .clear_cnt_i(clr), .match_o(m), .err_o(e), .frame_done_o(f), .err_count_o(cnt)
    );

    serial_word_checker #(.CNT_W(2)) dut_s (
        .clk_i(clk), .rst_i(rst), .din_i(din), .din_valid_i(din_valid), .mode_i(mode),
        .clear_cnt_i(clr), .match_o(ms), .err_o(es), .frame_done_o(fs), .err_count_o(cnt_s)
    );

    task automatic drive(input logic r, input logic md, input logic v, input logic d, input logic c);
        @(negedge clk);
        rst = r;
        mode = md;
        din_valid = v;
        din = d;
        clr = c;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            drive(i < 2, 1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            checks++;
            if (obs !== 16'h0) begin
                failures++;
                $display("FAIL reset step %0d obs=%h exp=%h", i, obs, 16'h0);
            end
        end
    endtask

    task automatic test_framed();
        logic [7:0] b, v;
        logic [2:0] p [8];
        b = 8'b11011101;
        v = 8'b11110011;
        p = '{3'b000, 3'b000, 3'b101, 3'b000, 3'b000, 3'b000, 3'b000, 3'b011};
        for (int i = 0; i < 8; i++) begin
            drive(1'b0, 1'b0, v[7-i], b[7-i], 1'b0);
            if (p[i][1]) begin
                ec = ec + 1'b1;
                ecs = (ecs == 2'd3) ? ecs : ecs + 1'b1;
            end
            checks++;
            if (obs !== {p[i], p[i], ec, ecs}) begin
                failures++;
                $display("FAIL framed step %0d obs=%h exp=%h", i, obs, {p[i], p[i], ec, ecs});
            end
        end
    endtask

    task automatic test_sliding();
        logic [12:0] md, v, b;
        logic [2:0]  p [13];
        md = 13'b1111111011111;
        v  = 13'b0111111001111;
        b  = 13'b0110110001110;
        p  = '{3'b000, 3'b000, 3'b000, 3'b100, 3'b000, 3'b000, 3'b100,
               3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b100};
        for (int i = 0; i < 13; i++) begin
            drive(1'b0, md[12-i], v[12-i], b[12-i], 1'b0);
            checks++;
            if (obs !== {p[i], p[i], ec, ecs}) begin
                failures++;
                $display("FAIL sliding step %0d obs=%h exp=%h", i, obs, {p[i], p[i], ec, ecs});
            end
        end
    endtask

    task automatic test_mode_change();
        logic [9:0] md, v, b;
        logic [2:0] p [10];
        md = 10'b0001111000;
        v  = 10'b0111111111;
        b  = 10'b0110110110;
        p  = '{3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b100, 3'b000, 3'b000, 3'b000};
        for (int i = 0; i < 10; i++) begin
            drive(1'b0, md[9-i], v[9-i], b[9-i], 1'b0);
            checks++;
            if (obs !== {p[i], p[i], ec, ecs}) begin
                failures++;
                $display("FAIL mode_change step %0d obs=%h exp=%h", i, obs, {p[i], p[i], ec, ecs});
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [10:0] md, v, b;
        logic [2:0]  p [11];
        md = 11'b10000000000;
        v  = 11'b00111111111;
        b  = 11'b00110110000;
        p  = '{3'b000, 3'b000, 3'b000, 3'b000, 3'b101, 3'b000, 3'b000, 3'b101, 3'b000, 3'b000, 3'b011};
        for (int i = 0; i < 11; i++) begin
            drive(1'b0, md[10-i], v[10-i], b[10-i], 1'b0);
            if (p[i][1]) begin
                ec = ec + 1'b1;
                ecs = (ecs == 2'd3) ? ecs : ecs + 1'b1;
            end
            checks++;
            if (obs !== {p[i], p[i], ec, ecs}) begin
                failures++;
                $display("FAIL back_to_back step %0d obs=%h exp=%h", i, obs, {p[i], p[i], ec, ecs});
            end
        end
    endtask

    task automatic test_saturation();
        logic [2:0] p;
        logic       v, c;
        for (int i = 0; i < 18; i++) begin
            v = i >= 2 && i < 17;
            c = i == 16;
            p = (v && (i - 2) % 3 == 2) ? 3'b011 : 3'b000;
            drive(1'b0, i == 0, v, 1'b0, c);
            if (c) begin
                ec = '0;
                ecs = '0;
            end else if (p[1]) begin
                ec = ec + 1'b1;
                ecs = (ecs == 2'd3) ? ecs : ecs + 1'b1;
            end
            checks++;
            if (obs !== {p, p, ec, ecs}) begin
                failures++;
                $display("FAIL saturation step %0d obs=%h exp=%h", i, obs, {p, p, ec, ecs});
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [6:0] r, b;
        logic [2:0] p [7];
        r = 7'b0010000;
        b = 7'b1100110;
        p = '{3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b011, 3'b000};
        for (int i = 0; i < 7; i++) begin
            drive(r[6-i], 1'b0, 1'b1, b[6-i], 1'b0);
            if (r[6-i]) begin
                ec = '0;
                ecs = '0;
            end else if (p[i][1]) begin
                ec = ec + 1'b1;
                ecs = (ecs == 2'd3) ? ecs : ecs + 1'b1;
            end
            checks++;
            if (obs !== {p[i], p[i], ec, ecs}) begin
                failures++;
                $display("FAIL reset_mid step %0d obs=%h exp=%h", i, obs, {p[i], p[i], ec, ecs});
            end
        end
    endtask

    initial begin
        test_reset();
        test_framed();
        test_sliding();
        test_mode_change();
        test_back_to_back();
        test_saturation();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
